conv_kxk_stream: RTL and testbench

- Parametrised successor to the fixed 3x3 row-streaming convolution engine.
- Accepts one column of M_LEN padded feature-map pixels per cycle and keeps an M_LEN x M_LEN sliding window.
- Multiplies the window by a run-time loadable signed kernel, then scales, optionally applies ReLU, saturates, and streams one result per window.
- Sits between the padding/line-buffer front end and the feature-map writer.

---
 rtl/conv_pkg.sv | 23 ++
 rtl/conv_sat_scale.sv | 37 +++
 rtl/conv_kxk_stream.sv | 185 ++++++++++++++++++
 tb/tb_conv_kxk_stream.sv | 323 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/conv_pkg.sv
// Shared types and defaults for the KxK streaming convolution engine.
package conv_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        WORK  = 2'b01,
        PAUSE = 2'b10
    } state_e;

    localparam int unsigned DEF_BIT_LEN  = 8;
    localparam int unsigned DEF_M_LEN    = 3;
    localparam int unsigned DEF_FEA_SIZE = 417;
    localparam int unsigned DEF_W_LEN    = 8;
    localparam int unsigned DEF_SHIFT    = 0;

    // Product width plus enough growth bits to sum every kernel tap without overflow.
    function automatic int unsigned acc_width(input int unsigned bit_len,
                                              input int unsigned w_len,
                                              input int unsigned m_len);
        return bit_len + w_len + 1 + $clog2(m_len * m_len);
    endfunction

endpackage

// File: rtl/conv_sat_scale.sv
// Arithmetic right shift of the accumulator followed by ReLU or signed saturation
// down to the output pixel width.
module conv_sat_scale #(
    parameter int unsigned ACC_W   = 21,
    parameter int unsigned BIT_LEN = 8,
    parameter int unsigned SHIFT   = 0
) (
    input  logic signed [ACC_W-1:0] i_acc,
    input  logic                    i_relu,
    output logic [BIT_LEN-1:0]      o_data_c
);
    localparam logic signed [ACC_W-1:0] UMAX = ACC_W'((2 ** BIT_LEN) - 1);
    localparam logic signed [ACC_W-1:0] SMAX = ACC_W'((2 ** (BIT_LEN - 1)) - 1);
    localparam logic signed [ACC_W-1:0] SMIN = ACC_W'(-(2 ** (BIT_LEN - 1)));

    logic signed [ACC_W-1:0] w_scaled;

    assign w_scaled = i_acc >>> SHIFT;

    always_comb begin
        o_data_c = w_scaled[BIT_LEN-1:0];
        if (i_relu) begin
            if (w_scaled[ACC_W-1]) begin
                o_data_c = '0;
            end else if (w_scaled > UMAX) begin
                o_data_c = '1;
            end
        end else begin
            if (w_scaled > SMAX) begin
                o_data_c = {1'b0, {(BIT_LEN-1){1'b1}}};
            end else if (w_scaled < SMIN) begin
                o_data_c = {1'b1, {(BIT_LEN-1){1'b0}}};
            end
        end
    end

endmodule

// File: rtl/conv_kxk_stream.sv
// Streaming M_LEN x M_LEN convolution: column-fed sliding window, loadable signed
// kernel, two-stage multiply / reduce-scale-saturate pipeline.
module conv_kxk_stream
    import conv_pkg::*;
#(
    parameter int unsigned BIT_LEN  = DEF_BIT_LEN,
    parameter int unsigned M_LEN    = DEF_M_LEN,
    parameter int unsigned FEA_SIZE = DEF_FEA_SIZE,
    parameter int unsigned W_LEN    = DEF_W_LEN,
    parameter int unsigned SHIFT    = DEF_SHIFT
) (
    input  logic                           i_Clk,
    input  logic                           i_reset,
    input  logic                           i_fStart,
    input  logic                           i_fStop,
    input  logic [M_LEN*BIT_LEN-1:0]       i_data,
    input  logic                           i_wEn,
    input  logic [$clog2(M_LEN*M_LEN)-1:0] i_wAddr,
    input  logic signed [W_LEN-1:0]        i_wData,
    input  logic                           i_relu,
    output logic [BIT_LEN-1:0]             o_data,
    output logic                           o_valid,
    output logic                           o_done,
    output logic                           o_busy
);
    localparam int unsigned NW   = M_LEN * M_LEN;
    localparam int unsigned AW   = $clog2(NW);
    localparam int unsigned PW   = BIT_LEN + W_LEN + 1;
    localparam int unsigned ACCW = acc_width(BIT_LEN, W_LEN, M_LEN);
    localparam int unsigned CW   = $clog2(FEA_SIZE + 1);

    state_e                  r_state, w_next;
    logic                    w_accept, w_launch, w_last, w_wen;
    logic [CW-1:0]           r_col, w_col_idx;
    logic [BIT_LEN-1:0]      r_win [M_LEN][M_LEN];
    logic signed [W_LEN-1:0] r_wgt [NW];
    logic signed [PW-1:0]    r_prod [NW];
    logic signed [ACCW-1:0]  w_sum;
    logic [BIT_LEN-1:0]      w_sat;
    logic                    r_v0, r_v1, r_last0, r_last1, r_relu0, r_relu1;
    logic [BIT_LEN-1:0]      r_data;
    logic                    r_valid, r_done, r_busy;

    // Columns are only taken while running; a paused cycle (including resume) shifts nothing.
    always_comb begin
        w_next   = r_state;
        w_accept = 1'b0;
        case (r_state)
            IDLE: begin
                if (i_fStart && !i_fStop) begin
                    w_next   = WORK;
                    w_accept = 1'b1;
                end
            end
            WORK: begin
                if (i_fStop) begin
                    w_next = IDLE;
                end else if (!i_fStart) begin
                    w_next = PAUSE;
                end else begin
                    w_accept = 1'b1;
                    if (r_col == CW'(FEA_SIZE - 1)) begin
                        w_next = IDLE;
                    end
                end
            end
            PAUSE: begin
                if (i_fStop) begin
                    w_next = IDLE;
                end else if (i_fStart) begin
                    w_next = WORK;
                end
            end
            default: w_next = IDLE;
        endcase
    end

    assign w_col_idx = (r_state == IDLE) ? '0 : r_col;
    assign w_last    = w_accept && (w_col_idx == CW'(FEA_SIZE - 1));
    assign w_launch  = w_accept && (w_col_idx >= CW'(M_LEN - 1));
    assign w_wen     = i_wEn && (r_state == IDLE) && !r_busy
                       && ({1'b0, i_wAddr} < (AW + 1)'(NW));

    always_ff @(posedge i_Clk or negedge i_reset) begin
        if (!i_reset) begin
            r_state <= IDLE;
            r_col   <= '0;
            r_busy  <= 1'b0;
        end else begin
            r_state <= w_next;
            if (w_accept) begin
                r_col <= w_last ? '0 : w_col_idx + CW'(1);
            end
            r_busy <= (w_next != IDLE) || w_launch || ((r_v0 || r_v1) && !i_fStop);
        end
    end

    always_ff @(posedge i_Clk or negedge i_reset) begin
        if (!i_reset) begin
            for (int r = 0; r < M_LEN; r++) begin
                for (int c = 0; c < M_LEN; c++) begin
                    r_win[r][c] <= '0;
                end
            end
            for (int i = 0; i < NW; i++) begin
                r_wgt[i] <= '0;
            end
        end else begin
            if (w_accept) begin
                for (int r = 0; r < M_LEN; r++) begin
                    for (int c = 0; c < M_LEN - 1; c++) begin
                        r_win[r][c] <= r_win[r][c+1];
                    end
                    r_win[r][M_LEN-1] <= i_data[r*BIT_LEN +: BIT_LEN];
                end
            end
            if (w_wen) begin
                r_wgt[i_wAddr] <= i_wData;
            end
        end
    end

    // Stop clears every valid bit on its own edge so nothing in flight escapes.
    always_ff @(posedge i_Clk or negedge i_reset) begin
        if (!i_reset) begin
            r_v0    <= 1'b0;
            r_v1    <= 1'b0;
            r_last0 <= 1'b0;
            r_last1 <= 1'b0;
            r_relu0 <= 1'b0;
            r_relu1 <= 1'b0;
            r_valid <= 1'b0;
            r_done  <= 1'b0;
            r_data  <= '0;
            for (int i = 0; i < NW; i++) begin
                r_prod[i] <= '0;
            end
        end else begin
            r_v0    <= w_launch;
            r_last0 <= w_last;
            if (w_accept) begin
                r_relu0 <= i_relu;
            end
            r_v1    <= r_v0 && !i_fStop;
            r_last1 <= r_last0 && !i_fStop;
            if (r_v0) begin
                r_relu1 <= r_relu0;
                for (int r = 0; r < M_LEN; r++) begin
                    for (int c = 0; c < M_LEN; c++) begin
                        r_prod[r*M_LEN+c] <= PW'($signed({1'b0, r_win[r][c]}))
                                             * PW'(r_wgt[r*M_LEN+c]);
                    end
                end
            end
            r_valid <= r_v1 && !i_fStop;
            r_done  <= r_v1 && r_last1 && !i_fStop;
            if (r_v1 && !i_fStop) begin
                r_data <= w_sat;
            end
        end
    end

    always_comb begin
        w_sum = '0;
        for (int i = 0; i < NW; i++) begin
            w_sum = w_sum + ACCW'(r_prod[i]);
        end
    end

    conv_sat_scale #(
        .ACC_W   (ACCW),
        .BIT_LEN (BIT_LEN),
        .SHIFT   (SHIFT)
    ) u_sat (
        .i_acc    (w_sum),
        .i_relu   (r_relu1),
        .o_data_c (w_sat)
    );

    assign o_data  = r_data;
    assign o_valid = r_valid;
    assign o_done  = r_done;
    assign o_busy  = r_busy;

endmodule

// File: tb/tb_conv_kxk_stream.sv
// Bench for conv_kxk_stream: directed and randomized rows checked every cycle
// against a window-sum reference with a per-result due-cycle queue.
module tb_conv_kxk_stream;
    localparam int unsigned BL = 8;
    localparam int unsigned ML = 3;
    localparam int unsigned WL = 8;
    localparam int unsigned SH = 0;
    localparam int unsigned FS = 8;
    localparam int NW = ML * ML;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              start, stop, wen, relu;
    logic [3:0]        waddr;
    logic signed [7:0] wdata;
    logic [ML*BL-1:0]  din;
    logic [7:0]        dout;
    logic              valid, done, busy;

    always #5 clk = ~clk;

    conv_kxk_stream #(
        .BIT_LEN(BL), .M_LEN(ML), .FEA_SIZE(FS), .W_LEN(WL), .SHIFT(SH)
    ) dut (
        .i_Clk(clk), .i_reset(rst_n), .i_fStart(start), .i_fStop(stop),
        .i_data(din), .i_wEn(wen), .i_wAddr(waddr), .i_wData(wdata),
        .i_relu(relu), .o_data(dout), .o_valid(valid), .o_done(done), .o_busy(busy)
    );

    typedef struct {
        int         due;
        logic [7:0] val;
        bit         last;
    } exp_t;

    exp_t       exp_q[$];
    int         row_pix [FS][ML];
    int         wgt [NW];
    int         wv [NW];
    int         m_st, m_col, cyc;
    bit         m_last_valid;
    logic [7:0] m_data;
    int         n_vec, n_err;
    logic [7:0] got[$];
    int         pause_valids, done_cnt;

    function automatic logic [7:0] ref_out(int j, bit rl);
        longint acc = 0;
        for (int r = 0; r < ML; r++)
            for (int c = 0; c < ML; c++)
                acc += longint'(row_pix[j-ML+1+c][r]) * longint'(wgt[r*ML+c]);
        acc = acc >>> SH;
        if (rl) begin
            if (acc < 0) acc = 0;
            else if (acc > 255) acc = 255;
        end else begin
            if (acc > 127) acc = 127;
            else if (acc < -128) acc = -128;
        end
        return acc[7:0];
    endfunction

    task automatic chk(string tag, logic [31:0] obs, logic [31:0] expv);
        n_vec++;
        assert (obs === expv) else begin
            n_err++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, expv);
        end
    endtask

    // One clock: model weight write / column acceptance, then compare all outputs.
    task automatic step(string tag);
        bit   acc;
        bit   busy_now;
        bit   due;
        int   idx;
        exp_t e;
        busy_now = (m_st != 0) || (exp_q.size() != 0) || m_last_valid;
        if (wen && m_st == 0 && !busy_now && waddr < NW) wgt[waddr] = int'(wdata);
        idx = (m_st == 0) ? 0 : m_col;
        for (int r = 0; r < ML; r++) din[r*BL +: BL] = 8'(row_pix[idx][r]);
        acc = !stop && start && (m_st != 2);
        @(posedge clk);
        cyc++;
        if (stop) begin
            m_st = 0;
            exp_q.delete();
        end else if (acc) begin
            if (idx >= ML - 1) begin
                e.due  = cyc + 2;
                e.val  = ref_out(idx, relu);
                e.last = (idx == FS - 1);
                exp_q.push_back(e);
            end
            m_col = idx + 1;
            m_st  = (idx == FS - 1) ? 0 : 1;
        end else if (m_st == 1 && !start) begin
            m_st = 2;
        end else if (m_st == 2 && start) begin
            m_st = 1;
        end
        #1;
        due = (exp_q.size() != 0) && (exp_q[0].due == cyc);
        chk({tag, ":busy"}, 32'(busy), 32'((m_st != 0) || (exp_q.size() != 0)));
        chk({tag, ":valid"}, 32'(valid), 32'(due));
        if (due) begin
            m_data = exp_q[0].val;
            chk({tag, ":done"}, 32'(done), 32'(exp_q[0].last));
            void'(exp_q.pop_front());
        end else begin
            chk({tag, ":done"}, 32'(done), 32'(0));
        end
        chk({tag, ":data"}, 32'(dout), 32'(m_data));
        if (valid === 1'b1) begin
            got.push_back(dout);
            if (m_st == 2) pause_valids++;
        end
        if (done === 1'b1) done_cnt++;
        m_last_valid = due;
    endtask

    task automatic load_w(string tag, input int w[NW]);
        start = 0;
        stop  = 0;
        for (int i = 0; i < NW; i++) begin
            wen   = 1;
            waddr = 4'(i);
            wdata = 8'(w[i]);
            step(tag);
        end
        wen = 0;
    endtask

    task automatic run_row(string tag, int pause_after, int pause_len);
        int guard = 0;
        int pc = 0;
        got.delete();
        pause_valids = 0;
        done_cnt = 0;
        start = 1;
        stop  = 0;
        wen   = 0;
        step(tag);
        while (m_st != 0 && guard < 100) begin
            if (pause_len > 0 && m_col == pause_after && pc < pause_len) begin
                start = 0;
                pc++;
            end else begin
                start = 1;
            end
            step(tag);
            guard++;
        end
        start = 0;
        repeat (4) step(tag);
    endtask

    task automatic fill_const(int a, int b, int c);
        for (int j = 0; j < FS; j++) begin
            row_pix[j][0] = a;
            row_pix[j][1] = b;
            row_pix[j][2] = c;
        end
    endtask

    task automatic fill_rand();
        for (int j = 0; j < FS; j++)
            for (int r = 0; r < ML; r++) row_pix[j][r] = int'($urandom_range(0, 255));
    endtask

    task automatic rand_w();
        for (int i = 0; i < NW; i++) wv[i] = int'($urandom_range(0, 255)) - 128;
    endtask

    initial begin
        n_vec = 0; n_err = 0; cyc = 0; m_st = 0; m_col = 0;
        m_data = '0; m_last_valid = 0; pause_valids = 0; done_cnt = 0;
        for (int i = 0; i < NW; i++) wgt[i] = 0;
        rst_n = 0; start = 0; stop = 0; wen = 0; relu = 0;
        waddr = '0; wdata = '0; din = '0;
        fill_const(0, 0, 0);
        #3;
        chk("rst:valid", 32'(valid), 32'(0));
        chk("rst:done", 32'(done), 32'(0));
        chk("rst:busy", 32'(busy), 32'(0));
        chk("rst:data", 32'(dout), 32'(0));
        @(negedge clk);
        rst_n = 1;
        @(posedge clk);
        #1;

        // All-ones kernel over constant rows 1/2/3.
        for (int i = 0; i < NW; i++) wv[i] = 1;
        load_w("ld1", wv);
        fill_const(1, 2, 3);
        relu = 0;
        run_row("ones", 0, 0);
        chk("ones:count", 32'(got.size()), 32'(6));
        chk("ones:first", 32'(got[0]), 32'h12);
        chk("ones:last", 32'(got[5]), 32'h12);
        chk("ones:donecnt", 32'(done_cnt), 32'(1));

        // Centre tap only, ramp on the middle row.
        for (int i = 0; i < NW; i++) wv[i] = 0;
        wv[4] = 2;
        load_w("ldc", wv);
        fill_rand();
        for (int j = 0; j < FS; j++) row_pix[j][1] = 10 + j;
        run_row("centre", 0, 0);
        chk("centre:count", 32'(got.size()), 32'(6));
        for (int k = 0; k < 6; k++) chk("centre:val", 32'(got[k]), 32'(22 + 2 * k));

        // Saturation corners.
        for (int i = 0; i < NW; i++) wv[i] = 127;
        load_w("lds", wv);
        fill_const(255, 255, 255);
        relu = 0;
        run_row("satpos_s", 0, 0);
        chk("satpos_s:val", 32'(got[0]), 32'h7F);
        relu = 1;
        run_row("satpos_u", 0, 0);
        chk("satpos_u:val", 32'(got[0]), 32'hFF);
        for (int i = 0; i < NW; i++) wv[i] = -1;
        load_w("ldn", wv);
        fill_const(10, 10, 10);
        relu = 1;
        run_row("neg_u", 0, 0);
        chk("neg_u:val", 32'(got[0]), 32'h00);
        relu = 0;
        run_row("neg_s", 0, 0);
        chk("neg_s:val", 32'(got[0]), 32'hA6);

        // Pause after the 4th column for 5 cycles.
        rand_w();
        load_w("ldp", wv);
        fill_rand();
        relu = 1'($urandom_range(0, 1));
        run_row("pause", 4, 5);
        chk("pause:count", 32'(got.size()), 32'(6));
        chk("pause:drain", 32'(pause_valids), 32'(2));
        for (int k = 0; k < 6; k++) chk("pause:val", 32'(got[k]), 32'(ref_out(k + 2, relu)));

        // Stop after the 5th column; a weight write during WORK must be ignored.
        rand_w();
        wv[0] = 3;
        load_w("ldt", wv);
        fill_rand();
        got.delete();
        done_cnt = 0;
        start = 1;
        step("stop");
        for (int g = 0; g < 20 && m_col < 5; g++) begin
            wen = (m_col == 2);
            waddr = 4'd0;
            wdata = 8'sd99;
            step("stop");
        end
        wen = 0;
        stop = 1;
        step("stop");
        stop = 0;
        start = 0;
        repeat (3) step("stop");
        chk("stop:busy", 32'(busy), 32'(0));
        chk("stop:donecnt", 32'(done_cnt), 32'(0));
        wen = 1; waddr = 4'd1; wdata = -8'sd7;
        step("stop_w");
        wen = 0;
        run_row("after_stop", 0, 0);
        chk("after_stop:count", 32'(got.size()), 32'(6));

        // Start and stop together in IDLE stays idle; out-of-range address is ignored.
        start = 1; stop = 1;
        step("both");
        start = 0; stop = 0;
        wen = 1; waddr = 4'd12; wdata = 8'sd55;
        step("both");
        wen = 0;
        repeat (2) step("both");

        // Randomized rows with random pauses.
        for (int t = 0; t < 3; t++) begin
            rand_w();
            load_w("ldr", wv);
            fill_rand();
            relu = 1'($urandom_range(0, 1));
            run_row("rand", int'($urandom_range(1, 6)), int'($urandom_range(1, 4)));
            chk("rand:count", 32'(got.size()), 32'(6));
        end

        // Asynchronous reset mid-row, then the all-ones run again.
        for (int i = 0; i < NW; i++) wv[i] = 1;
        load_w("ld1b", wv);
        fill_const(1, 2, 3);
        relu = 0;
        start = 1;
        repeat (4) step("mid");
        #2;
        rst_n = 0;
        #1;
        chk("arst:valid", 32'(valid), 32'(0));
        chk("arst:data", 32'(dout), 32'(0));
        chk("arst:busy", 32'(busy), 32'(0));
        chk("arst:done", 32'(done), 32'(0));
        m_st = 0; m_col = 0; m_data = '0; m_last_valid = 0;
        exp_q.delete();
        for (int i = 0; i < NW; i++) wgt[i] = 0;
        start = 0; stop = 0; wen = 0;
        @(negedge clk);
        rst_n = 1;
        @(posedge clk);
        #1;
        repeat (2) step("post_rst");
        load_w("ld1c", wv);
        run_row("ones2", 0, 0);
        chk("ones2:count", 32'(got.size()), 32'(6));
        chk("ones2:first", 32'(got[0]), 32'h12);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
